// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set request at or after start, wrapping 7 -> 0.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0]   lo_mask;
  logic [N_REQ-1:0]   hi_part;
  logic [2*N_REQ-1:0] dbl;

  // Lower half holds requests at/after start, upper half the full vector for the wrapped lap;
  // the lowest set bit of the concatenation is the winner.
  always_comb begin
    lo_mask = (N_REQ'(1) << start) - N_REQ'(1);
    hi_part = req & ~lo_mask;
    dbl     = {req, hi_part};
    found   = 1'b0;
    idx     = '0;
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (dbl[i]) begin
        found = 1'b1;
        idx   = i[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant.
// Optional forced release after MAX_HOLD busy cycles: define RR_ARBITER_TIMEOUT_EN.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_8: MAX_HOLD must be in 1..255");
  end

  state_t           state;
  logic [IDX_W-1:0] last_ptr;
  logic [IDX_W-1:0] start;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  assign start = last_ptr + IDX_W'(1);

  rr_pick8 u_pick (
    .req   (req),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_ptr  <= 3'd7;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            state     <= BUSY;
            gnt_idx   <= pick_idx;
            gnt       <= onehot8(pick_idx);
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        BUSY: begin
          // Disable wins over both release paths and leaves the pointer alone.
          if (!en) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
          end else if (!req[gnt_idx]) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            last_ptr  <= gnt_idx;
            hold_cnt  <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            last_ptr  <= gnt_idx;
            hold_cnt  <= '0;
            timeout   <= 1'b1;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_ptr  <= 3'd7;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            state     <= BUSY;
            gnt_idx   <= pick_idx;
            gnt       <= onehot8(pick_idx);
            gnt_valid <= 1'b1;
          end
        end
        BUSY: begin
          // Disable wins over release and leaves the pointer alone.
          if (!en) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end else if (!req[gnt_idx]) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            last_ptr  <= gnt_idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
